// File: rtl/crgu_pkg.sv
// -----------------------------------------------------------------------------
// crgu_pkg
// Shared types and constants for the crgu clock-enable sequencer.
//   ch_state_e      : per-channel sequencer state (OFF, WAKE, ON, HOLD), 2-bit
//   *_DEF           : default parameter values for crgu_clk_ctrl
//   div_slice()     : extracts channel ch's divide ratio from the packed bus
// -----------------------------------------------------------------------------
package crgu_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } ch_state_e;

  localparam int unsigned NUM_CH_DEF      = 4;
  localparam int unsigned DIV_W_DEF       = 4;
  localparam int unsigned HOLD_CYC_DEF    = 8;
  localparam int unsigned WAKE_CYC_DEF    = 2;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // Upper bounds for the packed divide bus (16 channels x 16-bit ratio)
  localparam int unsigned DIV_W_MAX   = 16;
  localparam int unsigned DIV_BUS_MAX = 256;

  // Return bits [ch*w +: w] of the divide bus, zero-extended to DIV_W_MAX
  function automatic logic [DIV_W_MAX-1:0] div_slice(
    input logic [DIV_BUS_MAX-1:0] bus,
    input int unsigned            ch,
    input int unsigned            w
  );
    logic [DIV_BUS_MAX-1:0] v_shift;
    logic [DIV_W_MAX-1:0]   v_mask;
    v_shift = bus >> (ch * w);
    // w == DIV_W_MAX shifts the one out entirely, so the subtraction wraps to all ones
    v_mask  = (DIV_W_MAX'(1) << w) - DIV_W_MAX'(1);
    return v_shift[DIV_W_MAX-1:0] & v_mask;
  endfunction

endpackage

// File: rtl/crgu_clk_ch.sv
// -----------------------------------------------------------------------------
// crgu_clk_ch
// One sequencer channel: request synchroniser, OFF/WAKE/ON/HOLD FSM with a
// shared wake/hold countdown, and the divided clock-enable strobe generator.
// Ports:
//   clk, rstn     : source clock, async active-low reset
//   i_req         : asynchronous level request
//   i_div         : divide ratio, sampled on WAKE->ON entry only
//   i_force_on    : treat as request in OFF; keeps HOLD/ON from reaching OFF
//   o_gate_en     : registered ICG enable (pre scan override)
//   o_ack         : registered level ack, clock running and stable
//   o_div_stb     : registered one-cycle strobe every div_q+1 cycles
// -----------------------------------------------------------------------------
module crgu_clk_ch
  import crgu_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
  parameter int unsigned WAKE_CYC    = WAKE_CYC_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_req,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_force_on,
  output logic             o_gate_en,
  output logic             o_ack,
  output logic             o_div_stb
);

  localparam logic [7:0] WAKE_LD   = 8'(WAKE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'((HOLD_CYC == 0) ? 0 : (HOLD_CYC - 1));
  localparam bit         HOLD_ZERO = (HOLD_CYC == 0);

  logic [SYNC_STAGES-1:0] r_sync;
  ch_state_e              r_state;
  ch_state_e              w_state_nxt;
  logic [7:0]             r_cnt;
  logic [7:0]             w_cnt_nxt;
  logic [DIV_W-1:0]       r_div_q;
  logic [DIV_W-1:0]       r_div_cnt;
  logic [DIV_W-1:0]       w_div_cnt_nxt;
  logic                   w_div_ld;
  logic                   w_req_s;
  logic                   w_run_now;
  logic                   w_run_nxt;
  logic                   w_stb_nxt;
  logic                   r_gate_en;
  logic                   r_ack;
  logic                   r_div_stb;

  assign w_req_s   = r_sync[SYNC_STAGES-1];
  assign w_run_now = (r_state == ST_ON) || (r_state == ST_HOLD);
  assign w_run_nxt = (w_state_nxt == ST_ON) || (w_state_nxt == ST_HOLD);

  // Request synchroniser shift chain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_req};
    end
  end

  // Next-state and countdown logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_ld    = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (w_req_s || i_force_on) begin
          w_state_nxt = ST_WAKE;
          w_cnt_nxt   = WAKE_LD;
        end else begin
          w_cnt_nxt   = 8'd0;
        end
      end
      ST_WAKE: begin
        // A request drop here is ignored; ON decides what happens next
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_ON;
          w_cnt_nxt   = 8'd0;
          w_div_ld    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      end
      ST_ON: begin
        if (w_req_s) begin
          w_state_nxt = ST_ON;
        end else if (HOLD_ZERO) begin
          if (i_force_on) begin
            w_state_nxt = ST_ON;
          end else begin
            w_state_nxt = ST_OFF;
          end
        end else begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (w_req_s) begin
          w_state_nxt = ST_ON;
        end else if (i_force_on) begin
          // Reloading each cycle makes the countdown restart when force drops
          w_cnt_nxt   = HOLD_LD;
        end else if (r_cnt == 8'd0) begin
          w_state_nxt = ST_OFF;
        end else begin
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Divider next value and strobe; strobe only while running this and next cycle
  always_comb begin
    w_div_cnt_nxt = '0;
    w_stb_nxt     = 1'b0;
    if (w_div_ld) begin
      w_div_cnt_nxt = '0;
    end else if (w_run_now && w_run_nxt) begin
      if (r_div_cnt == r_div_q) begin
        w_div_cnt_nxt = '0;
        w_stb_nxt     = 1'b1;
      end else begin
        w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
      end
    end else begin
      w_div_cnt_nxt = '0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_OFF;
      r_cnt     <= 8'd0;
      r_div_q   <= '0;
      r_div_cnt <= '0;
      r_gate_en <= 1'b0;
      r_ack     <= 1'b0;
      r_div_stb <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      if (w_div_ld) begin
        r_div_q <= i_div;
      end
      r_gate_en <= (w_state_nxt != ST_OFF);
      r_ack     <= w_run_nxt;
      r_div_stb <= w_stb_nxt;
    end
  end

  assign o_gate_en = r_gate_en;
  assign o_ack     = r_ack;
  assign o_div_stb = r_div_stb;

endmodule

// File: rtl/crgu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// crgu_clk_ctrl
// N-channel clock-enable sequencer for one source clock domain.
// Optional feature macro: CRGU_CLK_FORCE_ON_EN (adds input force_on).
// Ports:
//   clk          : source clock, post scan mux
//   rstn         : async active-low reset
//   scan_enable  : forces every ch_gate_en bit high
//   force_on     : (CRGU_CLK_FORCE_ON_EN only) wake all channels, block OFF
//   ch_req       : async level requests, one per channel
//   ch_div       : packed divide ratios, channel i at [i*DIV_W +: DIV_W]
//   ch_gate_en   : ICG enables
//   ch_ack       : level acks
//   ch_div_stb   : divided clock-enable strobes
//   busy         : some channel is not OFF
// -----------------------------------------------------------------------------
module crgu_clk_ctrl
  import crgu_pkg::*;
#(
  parameter int unsigned NUM_CH      = NUM_CH_DEF,
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
  parameter int unsigned WAKE_CYC    = WAKE_CYC_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    scan_enable,
`ifdef CRGU_CLK_FORCE_ON_EN
  input  logic                    force_on,
`endif
  input  logic [NUM_CH-1:0]       ch_req,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic [NUM_CH-1:0]       ch_gate_en,
  output logic [NUM_CH-1:0]       ch_ack,
  output logic [NUM_CH-1:0]       ch_div_stb,
  output logic                    busy
);

  logic [NUM_CH-1:0]      w_gate_en;
  logic [DIV_BUS_MAX-1:0] w_div_bus;
  logic                   w_force_on;

`ifdef CRGU_CLK_FORCE_ON_EN
  assign w_force_on = force_on;
`else
  assign w_force_on = 1'b0;
`endif

  assign w_div_bus = DIV_BUS_MAX'(ch_div);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DIV_W-1:0] w_div;
    assign w_div = DIV_W'(div_slice(w_div_bus, gi, DIV_W));

    crgu_clk_ch #(
      .DIV_W       (DIV_W),
      .HOLD_CYC    (HOLD_CYC),
      .WAKE_CYC    (WAKE_CYC),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .i_req      (ch_req[gi]),
      .i_div      (w_div),
      .i_force_on (w_force_on),
      .o_gate_en  (w_gate_en[gi]),
      .o_ack      (ch_ack[gi]),
      .o_div_stb  (ch_div_stb[gi])
    );
  end

  // Registered gate enable is high exactly when the channel is not OFF
  assign busy       = |w_gate_en;
  // Scan override sits after the registers so FSM, ack and strobe are untouched
  assign ch_gate_en = w_gate_en | {NUM_CH{scan_enable}};

endmodule

// File: tb/tb_crgu_clk_ctrl.sv
module tb_crgu_clk_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        scan_enable;
  logic [3:0]  ch_req;
  logic [15:0] ch_div;
  logic [3:0]  ch_gate_en;
  logic [3:0]  ch_ack;
  logic [3:0]  ch_div_stb;
  logic        busy;

  // second instance: HOLD_CYC = 0
  logic        z_scan;
  logic [3:0]  z_req;
  logic [15:0] z_div;
  logic [3:0]  z_gate_en;
  logic [3:0]  z_ack;
  logic [3:0]  z_div_stb;
  logic        z_busy;
`ifdef CRGU_CLK_FORCE_ON_EN
  logic        m_force;
  logic        z_force;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  crgu_clk_ctrl #(
    .NUM_CH(4), .DIV_W(4), .HOLD_CYC(8), .WAKE_CYC(2), .SYNC_STAGES(2)
  ) u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .scan_enable (scan_enable),
`ifdef CRGU_CLK_FORCE_ON_EN
    .force_on    (m_force),
`endif
    .ch_req      (ch_req),
    .ch_div      (ch_div),
    .ch_gate_en  (ch_gate_en),
    .ch_ack      (ch_ack),
    .ch_div_stb  (ch_div_stb),
    .busy        (busy)
  );

  crgu_clk_ctrl #(
    .NUM_CH(4), .DIV_W(4), .HOLD_CYC(0), .WAKE_CYC(2), .SYNC_STAGES(2)
  ) u_dut0 (
    .clk         (clk),
    .rstn        (rstn),
    .scan_enable (z_scan),
`ifdef CRGU_CLK_FORCE_ON_EN
    .force_on    (z_force),
`endif
    .ch_req      (z_req),
    .ch_div      (z_div),
    .ch_gate_en  (z_gate_en),
    .ch_ack      (z_ack),
    .ch_div_stb  (z_div_stb),
    .busy        (z_busy)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn        = 1'b0;
    scan_enable = 1'b0;
    ch_req      = 4'h0;
    ch_div      = 16'h0000;
    z_scan      = 1'b0;
    z_req       = 4'h0;
    z_div       = 16'h0000;
`ifdef CRGU_CLK_FORCE_ON_EN
    m_force     = 1'b0;
    z_force     = 1'b0;
`endif

    // ---- reset state
    step(2);
    chk("rst_gate", ch_gate_en, 4'h0);
    chk("rst_ack",  ch_ack,     4'h0);
    chk("rst_stb",  ch_div_stb, 4'h0);
    chk("rst_busy", {3'b000, busy}, 4'h0);
    rstn = 1'b1;
    step(2);

    // ---- basic on/off on channel 1 (cycle 0 = now)
    ch_req = 4'b0010;
    step(2);
    chk("on_gate_c2", ch_gate_en, 4'b0000);
    step(1);
    chk("on_gate_c3", ch_gate_en, 4'b0010);
    chk("on_ack_c3",  ch_ack,     4'b0000);
    step(1);
    chk("on_ack_c4",  ch_ack,     4'b0000);
    step(1);
    chk("on_ack_c5",  ch_ack,     4'b0010);
    chk("on_busy_c5", {3'b000, busy}, 4'b0001);
    step(15);
    ch_req = 4'b0000;                       // cycle 20
    step(10);
    chk("off_gate_c30", ch_gate_en, 4'b0010);
    chk("off_ack_c30",  ch_ack,     4'b0010);
    chk("off_stb_c30",  ch_div_stb, 4'b0010);
    step(1);
    chk("off_gate_c31", ch_gate_en, 4'b0000);
    chk("off_ack_c31",  ch_ack,     4'b0000);
    chk("off_stb_c31",  ch_div_stb, 4'b0000);
    chk("off_busy_c31", {3'b000, busy}, 4'b0000);

    // ---- hold re-grab on channel 0
    ch_req = 4'b0001;
    step(8);
    chk("rg_ack_on", ch_ack, 4'b0001);
    ch_req = 4'b0000;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 4) ch_req = 4'b0001;
      chk("rg_ack_hold",  ch_ack,     4'b0001);
      chk("rg_gate_hold", ch_gate_en, 4'b0001);
    end
    ch_req = 4'b0000;
    step(10);
    chk("rg_gate_c10", ch_gate_en, 4'b0001);
    step(1);
    chk("rg_gate_c11", ch_gate_en, 4'b0000);
    chk("rg_ack_c11",  ch_ack,     4'b0000);

    // ---- divider on channel 2, ratio 3
    ch_div = 16'h0300;
    ch_req = 4'b0100;
    step(5);
    chk("dv_ack",   ch_ack,     4'b0100);
    chk("dv_stb_0", ch_div_stb, 4'b0000);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("dv_stb_p4", ch_div_stb, ((k % 4) == 0) ? 4'b0100 : 4'b0000);
      if (k == 2) ch_div = 16'h0000;      // ignored until next wake
    end
    ch_req = 4'b0000;
    step(12);
    chk("dv_gate_off", ch_gate_en, 4'b0000);
    chk("dv_stb_off",  ch_div_stb, 4'b0000);
    ch_req = 4'b0100;
    step(5);
    chk("dv2_ack",   ch_ack,     4'b0100);
    chk("dv2_stb_0", ch_div_stb, 4'b0000);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk("dv2_stb_p1", ch_div_stb, 4'b0100);
    end

    // ---- reset mid-operation
    ch_req = 4'hF;
    step(8);
    chk("mr_ack_all", ch_ack, 4'hF);
    ch_req = 4'b0111;
    step(4);
    chk("mr_ack_hold", ch_ack, 4'hF);
    rstn = 1'b0;
    #1;
    chk("mr_gate", ch_gate_en, 4'h0);
    chk("mr_ack",  ch_ack,     4'h0);
    chk("mr_stb",  ch_div_stb, 4'h0);
    chk("mr_busy", {3'b000, busy}, 4'h0);
    ch_req = 4'hF;
    step(1);
    rstn = 1'b1;                            // cycle 0
    step(2);
    chk("mr_rel_gate_c2", ch_gate_en, 4'h0);
    step(1);
    chk("mr_rel_gate_c3", ch_gate_en, 4'hF);
    step(1);
    chk("mr_rel_ack_c4",  ch_ack,     4'h0);
    step(1);
    chk("mr_rel_ack_c5",  ch_ack,     4'hF);

    // ---- scan override
    ch_req = 4'h0;
    step(15);
    chk("sc_gate_pre", ch_gate_en, 4'h0);
    scan_enable = 1'b1;
    #1;
    chk("sc_gate", ch_gate_en, 4'hF);
    chk("sc_ack",  ch_ack,     4'h0);
    chk("sc_busy", {3'b000, busy}, 4'h0);
    step(2);
    chk("sc_gate_hold", ch_gate_en, 4'hF);
    chk("sc_ack_hold",  ch_ack,     4'h0);
    scan_enable = 1'b0;
    #1;
    chk("sc_gate_rel", ch_gate_en, 4'h0);

    // ---- HOLD_CYC = 0 instance: gate drops SYNC_STAGES+1 after request fall
    z_req = 4'b0001;
    step(5);
    chk("h0_ack", z_ack, 4'b0001);
    z_req = 4'b0000;
    step(2);
    chk("h0_gate_c2", z_gate_en, 4'b0001);
    step(1);
    chk("h0_gate_c3", z_gate_en, 4'b0000);
    chk("h0_ack_c3",  z_ack,     4'b0000);
    chk("h0_busy_c3", {3'b000, z_busy}, 4'b0000);

`ifdef CRGU_CLK_FORCE_ON_EN
    // ---- force_on on the HOLD_CYC = 0 instance
    z_force = 1'b1;
    step(1);
    chk("fo_gate_c1", z_gate_en, 4'hF);
    step(1);
    chk("fo_ack_c2",  z_ack,     4'h0);
    step(1);
    chk("fo_ack_c3",  z_ack,     4'hF);
    step(3);
    chk("fo_ack_hold", z_ack,    4'hF);
    z_force = 1'b0;
    step(1);
    chk("fo_gate_drop", z_gate_en, 4'h0);
    chk("fo_ack_drop",  z_ack,     4'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
